// File: rtl/sc_register_bank_if.sv
// C-bus write port and register read-out bundle of the datapath register bank.
interface sc_register_bank_if #(
  parameter int DATAWIDTH_BUS                 = 32,
  parameter int DATAWIDTH_SCRATCHPAD_DIRECTION = 5,
  parameter int DATAWIDTH_MIR_DIRECTION        = 6
);
  logic [DATAWIDTH_BUS-1:0]                  SC_REGBANK_data_InBus;
  logic                                      SC_REGBANK_Write_In;
  logic                                      SC_REGBANK_Select_In;
  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] SC_REGBANK_ScratchpadSelection_InBus;
  logic [DATAWIDTH_MIR_DIRECTION-1:0]        SC_REGBANK_MIRSelection_InBus;
  logic [DATAWIDTH_BUS-1:0] SC_REGBANK_data0_OutBus,  SC_REGBANK_data1_OutBus;
  logic [DATAWIDTH_BUS-1:0] SC_REGBANK_data2_OutBus,  SC_REGBANK_data3_OutBus;
  logic [DATAWIDTH_BUS-1:0] SC_REGBANK_data4_OutBus,  SC_REGBANK_data5_OutBus;
  logic [DATAWIDTH_BUS-1:0] SC_REGBANK_data6_OutBus,  SC_REGBANK_data7_OutBus;
  logic [DATAWIDTH_BUS-1:0] SC_REGBANK_data8_OutBus,  SC_REGBANK_data9_OutBus;
  logic [DATAWIDTH_BUS-1:0] SC_REGBANK_data10_OutBus, SC_REGBANK_data11_OutBus;
  logic [DATAWIDTH_BUS-1:0] SC_REGBANK_data12_OutBus, SC_REGBANK_data13_OutBus;
  logic [DATAWIDTH_BUS-1:0] SC_REGBANK_data14_OutBus, SC_REGBANK_data15_OutBus;
  logic                     SC_REGBANK_WriteAck_Out;
  logic                     SC_REGBANK_WriteIgnored_Out;

  modport master (
    output SC_REGBANK_data_InBus, SC_REGBANK_Write_In, SC_REGBANK_Select_In,
           SC_REGBANK_ScratchpadSelection_InBus, SC_REGBANK_MIRSelection_InBus,
    input  SC_REGBANK_data0_OutBus,  SC_REGBANK_data1_OutBus,  SC_REGBANK_data2_OutBus,
           SC_REGBANK_data3_OutBus,  SC_REGBANK_data4_OutBus,  SC_REGBANK_data5_OutBus,
           SC_REGBANK_data6_OutBus,  SC_REGBANK_data7_OutBus,  SC_REGBANK_data8_OutBus,
           SC_REGBANK_data9_OutBus,  SC_REGBANK_data10_OutBus, SC_REGBANK_data11_OutBus,
           SC_REGBANK_data12_OutBus, SC_REGBANK_data13_OutBus, SC_REGBANK_data14_OutBus,
           SC_REGBANK_data15_OutBus, SC_REGBANK_WriteAck_Out, SC_REGBANK_WriteIgnored_Out
  );

  modport slave (
    input  SC_REGBANK_data_InBus, SC_REGBANK_Write_In, SC_REGBANK_Select_In,
           SC_REGBANK_ScratchpadSelection_InBus, SC_REGBANK_MIRSelection_InBus,
    output SC_REGBANK_data0_OutBus,  SC_REGBANK_data1_OutBus,  SC_REGBANK_data2_OutBus,
           SC_REGBANK_data3_OutBus,  SC_REGBANK_data4_OutBus,  SC_REGBANK_data5_OutBus,
           SC_REGBANK_data6_OutBus,  SC_REGBANK_data7_OutBus,  SC_REGBANK_data8_OutBus,
           SC_REGBANK_data9_OutBus,  SC_REGBANK_data10_OutBus, SC_REGBANK_data11_OutBus,
           SC_REGBANK_data12_OutBus, SC_REGBANK_data13_OutBus, SC_REGBANK_data14_OutBus,
           SC_REGBANK_data15_OutBus, SC_REGBANK_WriteAck_Out, SC_REGBANK_WriteIgnored_Out
  );
endinterface

// File: rtl/sc_register_bank.sv
// 16-entry general-purpose register bank. r0 is hardwired to zero; one C-bus
// write per clock, destination taken from the IR rd field or the MIR C field.
module sc_register_bank #(
  parameter int                     DATAWIDTH_BUS                 = 32,
  parameter int                     DATAWIDTH_SCRATCHPAD_DIRECTION = 5,
  parameter int                     DATAWIDTH_MIR_DIRECTION        = 6,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_VALUE_R14             = 32'h0000_0000
) (
  input logic               SC_REGBANK_CLOCK_50,
  input logic               SC_REGBANK_RESET_InLow,
  sc_register_bank_if.slave bus
);

  localparam int AW = DATAWIDTH_MIR_DIRECTION;
  localparam logic [AW-1:0] ADDR_ZERO  = AW'(0);
  localparam logic [AW-1:0] ADDR_LIMIT = AW'(16);

  // r1..r15 only; r0 has no storage since it always reads zero.
  logic [15:1][DATAWIDTH_BUS-1:0] regs_q, regs_d;
  logic                           ack_q, ack_d;
  logic                           ign_q, ign_d;
  logic [AW-1:0]                  addr_s;
  logic                           addr_ok_s;

  // Effective destination: IR field is zero-extended so it is compared at full width.
  assign addr_s = bus.SC_REGBANK_Select_In
                ? bus.SC_REGBANK_MIRSelection_InBus
                : {{(AW-DATAWIDTH_SCRATCHPAD_DIRECTION){1'b0}}, bus.SC_REGBANK_ScratchpadSelection_InBus};

  // Only 1..15 are writable; 16..63 must not alias low registers.
  assign addr_ok_s = (addr_s != ADDR_ZERO) && (addr_s < ADDR_LIMIT);

  // Next-state: at most one register loads; status reports accepted vs discarded write.
  always_comb begin
    regs_d = regs_q;
    ack_d  = 1'b0;
    ign_d  = 1'b0;
    if (bus.SC_REGBANK_Write_In) begin
      if (addr_ok_s) begin
        regs_d[addr_s[3:0]] = bus.SC_REGBANK_data_InBus;
        ack_d               = 1'b1;
      end else begin
        ign_d = 1'b1;
      end
    end else begin
      ack_d = 1'b0;
      ign_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset that overrides any write.
  always_ff @(posedge SC_REGBANK_CLOCK_50) begin
    if (!SC_REGBANK_RESET_InLow) begin
      for (int i = 1; i < 16; i++) begin
        if (i == 14) begin
          regs_q[i] <= RESET_VALUE_R14;
        end else begin
          regs_q[i] <= {DATAWIDTH_BUS{1'b0}};
        end
      end
      ack_q <= 1'b0;
      ign_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      ack_q  <= ack_d;
      ign_q  <= ign_d;
    end
  end

  assign bus.SC_REGBANK_data0_OutBus     = {DATAWIDTH_BUS{1'b0}};
  assign bus.SC_REGBANK_data1_OutBus     = regs_q[1];
  assign bus.SC_REGBANK_data2_OutBus     = regs_q[2];
  assign bus.SC_REGBANK_data3_OutBus     = regs_q[3];
  assign bus.SC_REGBANK_data4_OutBus     = regs_q[4];
  assign bus.SC_REGBANK_data5_OutBus     = regs_q[5];
  assign bus.SC_REGBANK_data6_OutBus     = regs_q[6];
  assign bus.SC_REGBANK_data7_OutBus     = regs_q[7];
  assign bus.SC_REGBANK_data8_OutBus     = regs_q[8];
  assign bus.SC_REGBANK_data9_OutBus     = regs_q[9];
  assign bus.SC_REGBANK_data10_OutBus    = regs_q[10];
  assign bus.SC_REGBANK_data11_OutBus    = regs_q[11];
  assign bus.SC_REGBANK_data12_OutBus    = regs_q[12];
  assign bus.SC_REGBANK_data13_OutBus    = regs_q[13];
  assign bus.SC_REGBANK_data14_OutBus    = regs_q[14];
  assign bus.SC_REGBANK_data15_OutBus    = regs_q[15];
  assign bus.SC_REGBANK_WriteAck_Out     = ack_q;
  assign bus.SC_REGBANK_WriteIgnored_Out = ign_q;

endmodule

// File: tb/tb_sc_register_bank.sv
// Scoreboard bench for sc_register_bank: the driver pushes the expected
// post-edge state of every cycle; a monitor pops and compares on the falling edge.
module tb_sc_register_bank;

  localparam logic [31:0] R14_RST = 32'h0000_0000;

  typedef struct packed {
    logic             ack;
    logic             ign;
    logic [15:0][31:0] regs;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  logic [15:0][31:0] model;
  logic [15:0][31:0] act;
  int   checks;
  int   errors;

  sc_register_bank_if bus ();

  sc_register_bank dut (
    .SC_REGBANK_CLOCK_50    (clk),
    .SC_REGBANK_RESET_InLow (rst_n),
    .bus                    (bus.slave)
  );

  assign act[0]  = bus.SC_REGBANK_data0_OutBus;
  assign act[1]  = bus.SC_REGBANK_data1_OutBus;
  assign act[2]  = bus.SC_REGBANK_data2_OutBus;
  assign act[3]  = bus.SC_REGBANK_data3_OutBus;
  assign act[4]  = bus.SC_REGBANK_data4_OutBus;
  assign act[5]  = bus.SC_REGBANK_data5_OutBus;
  assign act[6]  = bus.SC_REGBANK_data6_OutBus;
  assign act[7]  = bus.SC_REGBANK_data7_OutBus;
  assign act[8]  = bus.SC_REGBANK_data8_OutBus;
  assign act[9]  = bus.SC_REGBANK_data9_OutBus;
  assign act[10] = bus.SC_REGBANK_data10_OutBus;
  assign act[11] = bus.SC_REGBANK_data11_OutBus;
  assign act[12] = bus.SC_REGBANK_data12_OutBus;
  assign act[13] = bus.SC_REGBANK_data13_OutBus;
  assign act[14] = bus.SC_REGBANK_data14_OutBus;
  assign act[15] = bus.SC_REGBANK_data15_OutBus;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus; upd/idx/val is the hand-computed register change.
  task automatic step(input logic rn, input logic wr, input logic sel,
                      input logic [4:0] sp, input logic [5:0] mir, input logic [31:0] data,
                      input logic upd, input int idx, input logic [31:0] val,
                      input logic e_ack, input logic e_ign);
    exp_t e;
    @(negedge clk);
    rst_n                                    = rn;
    bus.SC_REGBANK_Write_In                  = wr;
    bus.SC_REGBANK_Select_In                 = sel;
    bus.SC_REGBANK_ScratchpadSelection_InBus = sp;
    bus.SC_REGBANK_MIRSelection_InBus        = mir;
    bus.SC_REGBANK_data_InBus                = data;
    @(posedge clk);
    #1;
    if (!rn) begin
      model     = '0;
      model[14] = R14_RST;
    end else if (upd) begin
      model[idx] = val;
    end
    e.ack  = e_ack;
    e.ign  = e_ign;
    e.regs = model;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the registered outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.SC_REGBANK_WriteAck_Out !== e.ack) begin
          errors++;
          $display("FAIL ack: got %b want %b (t=%0t)", bus.SC_REGBANK_WriteAck_Out, e.ack, $time);
        end
        checks++;
        if (bus.SC_REGBANK_WriteIgnored_Out !== e.ign) begin
          errors++;
          $display("FAIL ign: got %b want %b (t=%0t)", bus.SC_REGBANK_WriteIgnored_Out, e.ign, $time);
        end
        for (int k = 0; k < 16; k++) begin
          checks++;
          if (act[k] !== e.regs[k]) begin
            errors++;
            $display("FAIL data%0d: got %h want %h (t=%0t)", k, act[k], e.regs[k], $time);
          end
        end
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    model  = '0;
    rst_n  = 1'b0;
    bus.SC_REGBANK_Write_In                  = 1'b0;
    bus.SC_REGBANK_Select_In                 = 1'b0;
    bus.SC_REGBANK_ScratchpadSelection_InBus = 5'd0;
    bus.SC_REGBANK_MIRSelection_InBus        = 6'd0;
    bus.SC_REGBANK_data_InBus                = 32'h0;

    // 1: reset held two clocks with a concurrent write to r3
    step(1'b0, 1'b1, 1'b0, 5'd3, 6'd3, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd3, 6'd3, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    // idle cycle: no write, no status
    step(1'b1, 1'b0, 1'b0, 5'd3, 6'd3, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    // 2: IR address 7
    step(1'b1, 1'b1, 1'b0, 5'd7, 6'd0, 32'h1234_5678, 1'b1, 7, 32'h1234_5678, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd7, 6'd0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    // 3: MIR 0 then 16 -> ignored, no alias to r0
    step(1'b1, 1'b1, 1'b1, 5'd1, 6'd0,  32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 5'd1, 6'd16, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1'b0, 1'b1);
    // MIR 17 must not alias r1; 63 out of range; IR 17 and 31 out of range; IR 0 ignored
    step(1'b1, 1'b1, 1'b1, 5'd1, 6'd17, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 5'd1, 6'd63, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 5'd17, 6'd1, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 5'd31, 6'd1, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 5'd0,  6'd1, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1'b0, 1'b1);
    // 4: back-to-back writes r1=1, r2=2, r1=3
    step(1'b1, 1'b1, 1'b0, 5'd1, 6'd0, 32'h0000_0001, 1'b1, 1, 32'h0000_0001, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd0, 6'd2, 32'h0000_0002, 1'b1, 2, 32'h0000_0002, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd1, 6'd0, 32'h0000_0003, 1'b1, 1, 32'h0000_0003, 1'b1, 1'b0);
    // accepted write directly followed by an ignored one
    step(1'b1, 1'b1, 1'b0, 5'd14, 6'd0, 32'h8000_0001, 1'b1, 14, 32'h8000_0001, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd14, 6'd32, 32'h7777_7777, 1'b0, 0, 32'h0, 1'b0, 1'b1);
    // 5: write r15, then reset with a concurrent r15 write
    step(1'b1, 1'b1, 1'b0, 5'd15, 6'd0, 32'hA5A5_A5A5, 1'b1, 15, 32'hA5A5_A5A5, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd15, 6'd0, 32'h5A5A_5A5A, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd15, 6'd0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    // 6: MIR selects r15 while IR field points at r4
    step(1'b1, 1'b1, 1'b1, 5'd4, 6'd15, 32'hCAFE_0000, 1'b1, 15, 32'hCAFE_0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd4, 6'd15, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);

    // drain the scoreboard with a bounded wait
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
